// File: rtl/piso_shreg_tx.sv
// Parallel-in serial-out transmitter: a one-deep holding register feeds a shifter
// that streams words out one bit per clock, back to back with no gap.
module piso_shreg_tx #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic             ready,
    output logic             dout,
    output logic             dvalid,
    output logic             done
);

    localparam int CountW = $clog2(WIDTH);
    localparam logic [CountW-1:0] LastCount = CountW'(WIDTH - 1);

    typedef enum logic {
        Idle,
        Shift
    } stateT;

    stateT             state;
    logic [WIDTH-1:0]  shifter;
    logic [WIDTH-1:0]  hold;
    logic [CountW-1:0] count;

    logic [WIDTH-1:0]  shifted;
    logic              holdOut;
    logic              shiftedOut;
    logic              transfer;

    // The output end of the shifter depends on bit order; vacated bits fill with 0.
    always_comb begin
        shifted    = '0;
        holdOut    = 1'b0;
        shiftedOut = 1'b0;
        if (MSB_FIRST) begin
            shifted    = {shifter[WIDTH-2:0], 1'b0};
            holdOut    = hold[WIDTH-1];
            shiftedOut = shifter[WIDTH-2];
        end else begin
            shifted    = {1'b0, shifter[WIDTH-1:1]};
            holdOut    = hold[0];
            shiftedOut = shifter[1];
        end
        transfer = !ready && ((state == Idle) || (count == '0));
    end

    // ready doubles as the hold-empty flag; a transfer needs ready=0, so it can never
    // coincide with an accept. Reloading on the last-bit cycle gives zero-gap streaming.
    always_ff @(posedge clk) begin
        if (clr) begin
            state   <= Idle;
            shifter <= '0;
            hold    <= '0;
            count   <= '0;
            ready   <= 1'b1;
            dout    <= 1'b0;
            dvalid  <= 1'b0;
            done    <= 1'b0;
        end else begin
            if (load && ready) begin
                hold  <= din;
                ready <= 1'b0;
            end else if (transfer) begin
                ready <= 1'b1;
            end

            done <= 1'b0;
            if (transfer) begin
                state   <= Shift;
                shifter <= hold;
                count   <= LastCount;
                dout    <= holdOut;
                dvalid  <= 1'b1;
            end else if ((state == Shift) && (count != '0)) begin
                shifter <= shifted;
                count   <= count - CountW'(1);
                dout    <= shiftedOut;
                done    <= (count == CountW'(1));
            end else begin
                state   <= Idle;
                shifter <= '0;
                count   <= '0;
                dout    <= 1'b0;
                dvalid  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_piso_shreg_tx.sv
// Directed bench for piso_shreg_tx: three instances (4-bit MSB-first, 4-bit LSB-first,
// 8-bit MSB-first feeding a SIPO) checked against hand-computed bit streams.
module tb_piso_shreg_tx;

    logic clk;
    logic clr;
    logic loadA, loadB, loadC;
    logic [3:0] dinA, dinB;
    logic [7:0] dinC;
    logic readyA, doutA, dvalidA, doneA;
    logic readyB, doutB, dvalidB, doneB;
    logic readyC, doutC, dvalidC, doneC;

    int checks   = 0;
    int failures = 0;

    logic [7:0] sipo;
    int         dvalidCountC;
    logic       found;

    piso_shreg_tx #(.WIDTH(4), .MSB_FIRST(1'b1)) dutA (
        .clk(clk), .clr(clr), .load(loadA), .din(dinA),
        .ready(readyA), .dout(doutA), .dvalid(dvalidA), .done(doneA)
    );

    piso_shreg_tx #(.WIDTH(4), .MSB_FIRST(1'b0)) dutB (
        .clk(clk), .clr(clr), .load(loadB), .din(dinB),
        .ready(readyB), .dout(doutB), .dvalid(dvalidB), .done(doneB)
    );

    piso_shreg_tx #(.WIDTH(8), .MSB_FIRST(1'b1)) dutC (
        .clk(clk), .clr(clr), .load(loadC), .din(dinC),
        .ready(readyC), .dout(doutC), .dvalid(dvalidC), .done(doneC)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream SIPO receiver for the 8-bit instance, plus a count of its valid cycles.
    always @(posedge clk) begin
        if (clr) begin
            sipo         <= '0;
            dvalidCountC <= 0;
        end else if (dvalidC) begin
            sipo         <= {sipo[6:0], doutC};
            dvalidCountC <= dvalidCountC + 1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int which, input logic [7:0] word);
        case (which)
            0:       begin loadA = 1'b1; dinA = word[3:0]; end
            1:       begin loadB = 1'b1; dinB = word[3:0]; end
            default: begin loadC = 1'b1; dinC = word;      end
        endcase
    endtask

    task automatic sampleDut(input int which, output logic r, output logic o,
                             output logic v, output logic d);
        case (which)
            0:       begin r = readyA; o = doutA; v = dvalidA; d = doneA; end
            1:       begin r = readyB; o = doutB; v = dvalidB; d = doneB; end
            default: begin r = readyC; o = doutC; v = dvalidC; d = doneC; end
        endcase
    endtask

    task automatic checkIdle(input string tag, input int which);
        logic r, o, v, d;
        sampleDut(which, r, o, v, d);
        checkOutput({tag, "_ready"},  {31'd0, r}, 32'd1);
        checkOutput({tag, "_dout"},   {31'd0, o}, 32'd0);
        checkOutput({tag, "_dvalid"}, {31'd0, v}, 32'd0);
        checkOutput({tag, "_done"},   {31'd0, d}, 32'd0);
    endtask

    // bits[n-1] is the first bit expected on dout; doneMask marks last-bit cycles.
    task automatic expectBits(input int which, input string tag, input logic [31:0] bits,
                              input logic [31:0] doneMask, input int n);
        logic r, o, v, d;
        for (int i = n - 1; i >= 0; i--) begin
            sampleDut(which, r, o, v, d);
            checkOutput($sformatf("%s_dvalid%0d", tag, n - 1 - i), {31'd0, v}, 32'd1);
            checkOutput($sformatf("%s_dout%0d", tag, n - 1 - i), {31'd0, o}, {31'd0, bits[i]});
            checkOutput($sformatf("%s_done%0d", tag, n - 1 - i), {31'd0, d}, {31'd0, doneMask[i]});
            nextCycle();
        end
    endtask

    initial begin
        clr   = 1'b1;
        loadA = 1'b0; loadB = 1'b0; loadC = 1'b0;
        dinA  = '0;   dinB  = '0;   dinC  = '0;
        repeat (2) @(posedge clk);
        #1;
        clr = 1'b0;
        checkIdle("rst_a", 0);
        checkIdle("rst_b", 1);
        checkIdle("rst_c", 2);

        // Single word from idle: first bit one cycle after the accept edge.
        applyStimulus(0, 8'h0B);
        nextCycle();
        loadA = 1'b0;
        checkOutput("t2_ready_after_accept", {31'd0, readyA}, 32'd0);
        checkOutput("t2_dvalid_before_xfer", {31'd0, dvalidA}, 32'd0);
        nextCycle();
        checkOutput("t2_ready_after_xfer", {31'd0, readyA}, 32'd1);
        expectBits(0, "t2", 32'b1011, 32'b0001, 4);
        checkIdle("t2_end", 0);

        // Two words streamed back to back.
        applyStimulus(0, 8'h0B);
        nextCycle();
        dinA = 4'b0110;
        checkOutput("t3_dvalid_pre", {31'd0, dvalidA}, 32'd0);
        nextCycle();
        fork
            expectBits(0, "t3", 32'b10110110, 32'b00010001, 8);
            begin
                nextCycle();
                loadA = 1'b0;
            end
        join
        checkIdle("t3_end", 0);

        // LOAD of 0001 while the hold register is full must be ignored.
        applyStimulus(0, 8'h0B);
        nextCycle();
        dinA = 4'b1111;
        nextCycle();
        fork
            expectBits(0, "t4", 32'b10111111, 32'b00010001, 8);
            begin
                nextCycle();
                dinA = 4'b0001;
                repeat (3) @(posedge clk);
                #1;
                loadA = 1'b0;
            end
        join
        checkIdle("t4_end", 0);
        nextCycle();
        checkOutput("t4_no_extra_word", {31'd0, dvalidA}, 32'd0);

        // Clear mid-stream with a second word waiting in hold: both are dropped.
        applyStimulus(0, 8'h0B);
        nextCycle();
        dinA = 4'b0110;
        nextCycle();
        nextCycle();
        loadA = 1'b0;
        clr   = 1'b1;
        nextCycle();
        clr = 1'b0;
        checkIdle("t1_clr", 0);
        for (int i = 0; i < 6; i++) begin
            nextCycle();
            checkOutput($sformatf("t1_not_resumed%0d", i), {31'd0, dvalidA}, 32'd0);
        end

        // LSB-first ordering.
        applyStimulus(1, 8'h0B);
        nextCycle();
        loadB = 1'b0;
        nextCycle();
        expectBits(1, "t5", 32'b1101, 32'b0001, 4);
        checkIdle("t5_end", 1);

        // 8-bit word captured by the downstream SIPO.
        applyStimulus(2, 8'hA5);
        nextCycle();
        loadC = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            nextCycle();
            if (doneC) found = 1'b1;
        end
        checkOutput("t6_done_seen", {31'd0, found}, 32'd1);
        nextCycle();
        checkOutput("t6_sipo", {24'd0, sipo}, 32'hA5);
        checkOutput("t6_dvalid_cycles", dvalidCountC, 32'd8);
        checkOutput("t6_dvalid_end", {31'd0, dvalidC}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
